// File: rtl/bpsk_tx_scheduler.sv
// Round-robin two-source BPSK transmit scheduler: alternating preamble, LSB-first payload, gap.
// First bit appears the clock after the handshake; sources are held off (ready=0) outside IDLE.
module bpsk_tx_scheduler #(
    parameter int PACKET_SIZE   = 16,
    parameter int WAVELENGTH    = 4,
    parameter int PREAMBLE_BITS = 8,
    parameter int GAP_CYCLES    = 8
) (
    input  logic                   clock,
    input  logic                   reset_n,
    input  logic                   req_valid_a,
    input  logic [PACKET_SIZE-1:0] req_data_a,
    output logic                   req_ready_a,
    input  logic                   req_valid_b,
    input  logic [PACKET_SIZE-1:0] req_data_b,
    output logic                   req_ready_b,
    output logic                   current_bit,
    output logic                   tx_active,
    output logic                   bit_strobe,
    output logic                   grant_b,
    output logic                   done
);
    localparam logic [1:0] S_IDLE     = 2'd0;
    localparam logic [1:0] S_PREAMBLE = 2'd1;
    localparam logic [1:0] S_SEND     = 2'd2;
    localparam logic [1:0] S_GAP      = 2'd3;

    localparam int BIT_MAX = (PACKET_SIZE > PREAMBLE_BITS) ? PACKET_SIZE : PREAMBLE_BITS;
    localparam int BW      = $clog2(BIT_MAX + 1);
    localparam int CW      = $clog2(WAVELENGTH + 1);
    localparam int GW      = (GAP_CYCLES > 0) ? $clog2(GAP_CYCLES + 1) : 1;

    localparam logic [CW-1:0] CYC_LAST = CW'(WAVELENGTH - 1);
    localparam logic [BW-1:0] PRE_LAST = BW'((PREAMBLE_BITS > 0) ? PREAMBLE_BITS - 1 : 0);
    localparam logic [BW-1:0] PKT_LAST = BW'(PACKET_SIZE - 1);
    localparam logic [GW-1:0] GAP_LAST = GW'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);
    localparam logic [1:0]    FIRST_TX = (PREAMBLE_BITS > 0) ? S_PREAMBLE : S_SEND;
    localparam logic [1:0]    AFTER_TX = (GAP_CYCLES > 0) ? S_GAP : S_IDLE;

    logic [1:0]             state;
    logic [BW-1:0]          bit_cnt;
    logic [CW-1:0]          cyc_cnt;
    logic [GW-1:0]          gap_cnt;
    logic [PACKET_SIZE-1:0] pkt_dat;
    logic [PACKET_SIZE-1:0] pkt_shift;
    logic                   rr_ptr;
    logic                   handshake;
    logic                   bit_last;

    // rr_ptr=1 means B wins a tie; only the winner ever sees ready.
    assign req_ready_a = (state == S_IDLE) && req_valid_a && !(req_valid_b && rr_ptr);
    assign req_ready_b = (state == S_IDLE) && req_valid_b && (!req_valid_a || rr_ptr);
    assign handshake   = req_ready_a || req_ready_b;

    assign bit_last  = (state == S_PREAMBLE) ? (bit_cnt == PRE_LAST) : (bit_cnt == PKT_LAST);
    assign pkt_shift = pkt_dat >> bit_cnt;

    always_comb begin
        tx_active   = (state == S_PREAMBLE) || (state == S_SEND);
        bit_strobe  = tx_active && (cyc_cnt == '0);
        current_bit = 1'b0;
        if (state == S_PREAMBLE)
            current_bit = ~bit_cnt[0];
        else if (state == S_SEND)
            current_bit = pkt_shift[0];
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state   <= S_IDLE;
            bit_cnt <= '0;
            cyc_cnt <= '0;
            gap_cnt <= '0;
            pkt_dat <= '0;
            rr_ptr  <= 1'b0;
            grant_b <= 1'b0;
            done    <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (handshake) begin
                        pkt_dat <= req_ready_b ? req_data_b : req_data_a;
                        grant_b <= req_ready_b;
                        rr_ptr  <= ~req_ready_b;
                        bit_cnt <= '0;
                        cyc_cnt <= '0;
                        state   <= FIRST_TX;
                    end
                end
                S_PREAMBLE, S_SEND: begin
                    if (cyc_cnt == CYC_LAST) begin
                        cyc_cnt <= '0;
                        if (bit_last) begin
                            bit_cnt <= '0;
                            if (state == S_PREAMBLE) begin
                                state <= S_SEND;
                            end else begin
                                state   <= AFTER_TX;
                                done    <= 1'b1;
                                gap_cnt <= '0;
                            end
                        end else begin
                            bit_cnt <= bit_cnt + BW'(1);
                        end
                    end else begin
                        cyc_cnt <= cyc_cnt + CW'(1);
                    end
                end
                S_GAP: begin
                    // The done cycle is the first of the gap cycles.
                    if (gap_cnt == GAP_LAST)
                        state <= S_IDLE;
                    else
                        gap_cnt <= gap_cnt + GW'(1);
                end
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_bpsk_tx_scheduler.sv
// Scoreboard bench: default-parameter DUT (index 0) and a minimal PRE=0/GAP=0/W=1/N=8 DUT (index 1).
module tb_bpsk_tx_scheduler;
    logic        clock = 1'b0;
    logic        reset_n = 1'b0;
    logic        req_valid_a = 1'b0, req_valid_b = 1'b0;
    logic [15:0] req_data_a = '0, req_data_b = '0;
    logic        req_ready_a, req_ready_b, current_bit, tx_active, bit_strobe, grant_b, done;
    logic        d2_valid_a = 1'b0, d2_valid_b = 1'b0;
    logic [7:0]  d2_data_a = '0, d2_data_b = '0;
    logic        d2_ready_a, d2_ready_b, d2_bit, d2_tx, d2_stb, d2_gnt, d2_done;

    int n_cmp = 0;
    int n_err = 0;
    int cyc = 0;

    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;

    bpsk_tx_scheduler dut (
        .clock(clock), .reset_n(reset_n),
        .req_valid_a(req_valid_a), .req_data_a(req_data_a), .req_ready_a(req_ready_a),
        .req_valid_b(req_valid_b), .req_data_b(req_data_b), .req_ready_b(req_ready_b),
        .current_bit(current_bit), .tx_active(tx_active), .bit_strobe(bit_strobe),
        .grant_b(grant_b), .done(done)
    );

    bpsk_tx_scheduler #(.PACKET_SIZE(8), .WAVELENGTH(1), .PREAMBLE_BITS(0), .GAP_CYCLES(0)) dut2 (
        .clock(clock), .reset_n(reset_n),
        .req_valid_a(d2_valid_a), .req_data_a(d2_data_a), .req_ready_a(d2_ready_a),
        .req_valid_b(d2_valid_b), .req_data_b(d2_data_b), .req_ready_b(d2_ready_b),
        .current_bit(d2_bit), .tx_active(d2_tx), .bit_strobe(d2_stb),
        .grant_b(d2_gnt), .done(d2_done)
    );

    logic        m_vld_a[2], m_vld_b[2], m_rdy_a[2], m_rdy_b[2];
    logic        m_tx[2], m_bit[2], m_stb[2], m_gnt[2], m_done[2];
    logic [15:0] m_dat_a[2], m_dat_b[2];
    assign m_vld_a[0] = req_valid_a;  assign m_vld_a[1] = d2_valid_a;
    assign m_vld_b[0] = req_valid_b;  assign m_vld_b[1] = d2_valid_b;
    assign m_rdy_a[0] = req_ready_a;  assign m_rdy_a[1] = d2_ready_a;
    assign m_rdy_b[0] = req_ready_b;  assign m_rdy_b[1] = d2_ready_b;
    assign m_tx[0]    = tx_active;    assign m_tx[1]    = d2_tx;
    assign m_bit[0]   = current_bit;  assign m_bit[1]   = d2_bit;
    assign m_stb[0]   = bit_strobe;   assign m_stb[1]   = d2_stb;
    assign m_gnt[0]   = grant_b;      assign m_gnt[1]   = d2_gnt;
    assign m_done[0]  = done;         assign m_done[1]  = d2_done;
    assign m_dat_a[0] = req_data_a;   assign m_dat_a[1] = {8'h00, d2_data_a};
    assign m_dat_b[0] = req_data_b;   assign m_dat_b[1] = {8'h00, d2_data_b};

    typedef struct {
        int          dut;
        bit          src;
        logic [15:0] data;
        int          spacing;
    } exp_t;

    exp_t q[$];
    exp_t cur[2];
    bit   busy[2] = '{0, 0};
    bit   seen[2] = '{0, 0};
    int   t_hs[2] = '{0, 0};
    int   last_hs[2] = '{0, 0};

    task automatic chk(input int d, input string nm, input int act, input int exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL d%0d %s: got %0h, required %0h (cycle %0d)", d, nm, act, exp, cyc);
        end
    endtask

    task automatic chk_quiet(input int d);
        chk(d, "q_tx_active", m_tx[d], 0);
        chk(d, "q_current_bit", m_bit[d], 0);
        chk(d, "q_bit_strobe", m_stb[d], 0);
        chk(d, "q_grant_b", m_gnt[d], 0);
        chk(d, "q_done", m_done[d], 0);
        chk(d, "q_ready_a", m_rdy_a[d], 0);
        chk(d, "q_ready_b", m_rdy_b[d], 0);
    endtask

    task automatic wait_ready(input int d, input bit src, input int budget);
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < budget && !ok; i++) begin
            @(negedge clock);
            ok = src ? (m_vld_b[d] && m_rdy_b[d]) : (m_vld_a[d] && m_rdy_a[d]);
        end
        n_cmp++;
        if (!ok) begin
            n_err++;
            $display("FAIL d%0d handshake_timeout src%0d: got no ready, required one within %0d cycles", d, src, budget);
        end
        @(posedge clock);
        #1;
    endtask

    // Monitor: derives every expected output from the popped grant and its cycle offset.
    always @(negedge clock) begin
        int pre, w, n, g, act, off, k;
        bit eb, hs_a, hs_b;
        exp_t e;
        if (!reset_n) begin
            busy[0] = 0; busy[1] = 0; seen[0] = 0; seen[1] = 0;
        end else begin
            for (int d = 0; d < 2; d++) begin
                pre = (d == 0) ? 8 : 0;
                w   = (d == 0) ? 4 : 1;
                n   = (d == 0) ? 16 : 8;
                g   = (d == 0) ? 8 : 0;
                act = (pre + n) * w;
                off = cyc - t_hs[d];
                chk(d, "grant_b", m_gnt[d], seen[d] ? cur[d].src : 0);
                if (busy[d]) begin
                    if (off <= act) begin
                        k  = (off - 1) / w;
                        eb = (k < pre) ? (k % 2 == 0) : cur[d].data[k - pre];
                        chk(d, "tx_active", m_tx[d], 1);
                        chk(d, "bit_strobe", m_stb[d], ((off - 1) % w) == 0);
                        chk(d, "current_bit", m_bit[d], eb);
                        chk(d, "done", m_done[d], 0);
                    end else begin
                        chk(d, "gap_tx_active", m_tx[d], 0);
                        chk(d, "gap_current_bit", m_bit[d], 0);
                        chk(d, "gap_bit_strobe", m_stb[d], 0);
                        chk(d, "done_timing", m_done[d], off == act + 1);
                    end
                    if (off < act + 1 + g) begin
                        chk(d, "busy_ready_a", m_rdy_a[d], 0);
                        chk(d, "busy_ready_b", m_rdy_b[d], 0);
                    end else begin
                        busy[d] = 0;
                    end
                end else begin
                    chk(d, "idle_tx_active", m_tx[d], 0);
                    chk(d, "idle_bit_strobe", m_stb[d], 0);
                    chk(d, "idle_current_bit", m_bit[d], 0);
                    chk(d, "idle_done", m_done[d], 0);
                end
                chk(d, "ready_onehot", m_rdy_a[d] && m_rdy_b[d], 0);
                hs_a = m_vld_a[d] && m_rdy_a[d];
                hs_b = m_vld_b[d] && m_rdy_b[d];
                if (hs_a || hs_b) begin
                    if (q.size() == 0 || q[0].dut != d) begin
                        n_cmp++;
                        n_err++;
                        $display("FAIL d%0d unexpected_grant: got handshake src%0d, required none (cycle %0d)", d, hs_b, cyc);
                    end else begin
                        e = q.pop_front();
                        chk(d, "grant_src", hs_b, e.src);
                        chk(d, "grant_data", hs_b ? m_dat_b[d] : m_dat_a[d], e.data);
                        if (e.spacing > 0) chk(d, "hs_spacing", cyc - last_hs[d], e.spacing);
                        cur[d] = e; busy[d] = 1; seen[d] = 1; t_hs[d] = cyc; last_hs[d] = cyc;
                    end
                end
            end
        end
    end

    initial begin
        repeat (3) @(posedge clock);
        #1;
        chk_quiet(0);
        chk_quiet(1);
        #1 reset_n = 1'b1;
        @(posedge clock); #1;
        chk_quiet(0);

        // A alone, 0xA5C3
        q.push_back('{0, 1'b0, 16'hA5C3, -1});
        req_data_a = 16'hA5C3; req_valid_a = 1'b1;
        wait_ready(0, 1'b0, 20);
        req_valid_a = 1'b0;
        repeat (110) @(posedge clock); #1;

        // B requests during A's packet, then a one-cycle A pulse while B is busy
        q.push_back('{0, 1'b0, 16'h1234, -1});
        q.push_back('{0, 1'b1, 16'hBEEF, 105});
        req_data_a = 16'h1234; req_valid_a = 1'b1;
        wait_ready(0, 1'b0, 20);
        req_valid_a = 1'b0;
        repeat (10) @(posedge clock); #1;
        req_data_b = 16'hBEEF; req_valid_b = 1'b1;
        wait_ready(0, 1'b1, 200);
        req_valid_b = 1'b0;
        repeat (20) @(posedge clock); #1;
        req_data_a = 16'h5555; req_valid_a = 1'b1;
        @(posedge clock); #1;
        req_valid_a = 1'b0;
        repeat (100) @(posedge clock); #1;

        // Reset 40 cycles into a packet
        q.push_back('{0, 1'b0, 16'h0F0F, -1});
        req_data_a = 16'h0F0F; req_valid_a = 1'b1;
        wait_ready(0, 1'b0, 20);
        req_valid_a = 1'b0;
        repeat (39) @(posedge clock);
        #2;
        chk(0, "pre_reset_tx_active", tx_active, 1);
        reset_n = 1'b0;
        #1;
        chk_quiet(0);
        @(posedge clock); #2;
        reset_n = 1'b1;
        repeat (3) @(posedge clock); #1;

        // Both valid continuously after reset: A,B,A,B at 105-cycle spacing
        q.push_back('{0, 1'b0, 16'h1111, -1});
        q.push_back('{0, 1'b1, 16'h2222, 105});
        q.push_back('{0, 1'b0, 16'h3333, 105});
        q.push_back('{0, 1'b1, 16'h4444, 105});
        req_data_a = 16'h1111; req_data_b = 16'h2222;
        req_valid_a = 1'b1; req_valid_b = 1'b1;
        wait_ready(0, 1'b0, 20);
        req_data_a = 16'h3333;
        wait_ready(0, 1'b1, 200);
        req_data_b = 16'h4444;
        wait_ready(0, 1'b0, 200);
        req_valid_a = 1'b0;
        wait_ready(0, 1'b1, 200);
        req_valid_b = 1'b0;
        repeat (110) @(posedge clock); #1;

        // Minimal configuration: B sends 8'h01 and re-handshakes on the done cycle
        q.push_back('{1, 1'b1, 16'h0001, -1});
        q.push_back('{1, 1'b1, 16'h0080, 9});
        d2_data_b = 8'h01; d2_valid_b = 1'b1;
        wait_ready(1, 1'b1, 20);
        d2_data_b = 8'h80;
        wait_ready(1, 1'b1, 30);
        d2_valid_b = 1'b0;
        repeat (15) @(posedge clock); #1;

        chk(0, "queue_empty", q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
